// File: rtl/sliding_window_agg.sv
// -----------------------------------------------------------------------------
// sliding_window_agg
//
// Sliding-window aggregator for the RTLola monitor datapath. Events from an
// input stream are accumulated into a ring of BUCKETS time buckets, each
// holding a partial sum and an event count. A slide closes the current bucket
// and evicts the oldest one. An evaluation request returns the sum and the
// count of every event still held in the window.
//
// Parameters
//   DATA_W   width of the signed event value and of all sum accumulators
//   BUCKETS  number of buckets in the ring (>= 2, power of two)
//   CNT_W    width of the per-bucket and window event counters
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears all state and outputs
//   en         clock enable; while low, all state holds and inputs are ignored
//   in_data    signed event value (two's complement)
//   in_valid   an event is presented this cycle
//   slide      close the current bucket and start a new one
//   req        evaluation request
//   out_sum    window sum, loaded on each request and held until the next
//   out_cnt    window event count, loaded on each request and held
//   out_valid  one-cycle pulse marking a response to req
//   out_full   at least BUCKETS-1 slides have occurred since reset
//
// Handshake: there is no backpressure. in_valid, slide and req are qualified
// only by en and are taken on the edge where they are high. Each accepted req
// produces out_valid high on exactly the following cycle, with out_sum/out_cnt
// holding the totals after that cycle's event and slide were applied.
// -----------------------------------------------------------------------------
module sliding_window_agg #(
    parameter int DATA_W  = 64,
    parameter int BUCKETS = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              slide,
    input  logic              req,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_valid,
    output logic              out_full
);

    localparam int                PTR_W    = (BUCKETS > 1) ? $clog2(BUCKETS) : 1;
    localparam logic [PTR_W-1:0]  FILL_MAX = PTR_W'(BUCKETS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [DATA_W-1:0] bsum [BUCKETS];
    logic [CNT_W-1:0]  bcnt [BUCKETS];

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  oldest;
    logic [PTR_W-1:0]  fill;
    logic [PTR_W-1:0]  fill_next;
    logic [DATA_W-1:0] tsum;
    logic [DATA_W-1:0] tsum_next;
    logic [CNT_W-1:0]  tcnt;
    logic [CNT_W-1:0]  tcnt_next;

    logic do_event;
    logic do_slide;
    logic do_req;
    logic cnt_inc;

    // Next-state of the running totals. An event and a slide in the same
    // cycle are combined: the event lands in the bucket being closed (ptr),
    // while the bucket after it (the oldest) is evicted, so the event stays
    // in the window.
    always_comb begin
        do_event  = en & in_valid;
        do_slide  = en & slide;
        do_req    = en & req;

        // BUCKETS is a power of two, so the ring wraps by plain overflow.
        oldest    = ptr + PTR_W'(1);

        // The window count only advances by what the bucket counter actually
        // absorbs. Because tcnt is exactly the sum of the bucket counts,
        // subtracting an evicted bucket count can never underflow it.
        cnt_inc   = do_event && (bcnt[ptr] != CNT_MAX);

        tsum_next = tsum;
        tcnt_next = tcnt;
        if (do_event) begin
            tsum_next = tsum_next + in_data;
        end
        if (cnt_inc) begin
            tcnt_next = tcnt_next + CNT_W'(1);
        end
        if (do_slide) begin
            tsum_next = tsum_next - bsum[oldest];
            tcnt_next = tcnt_next - bcnt[oldest];
        end

        fill_next = fill;
        if (do_slide && (fill != FILL_MAX)) begin
            fill_next = fill + PTR_W'(1);
        end
    end

    // Bucket storage. oldest and ptr are always different buckets, so the
    // clear on slide and the accumulate on event never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUCKETS; i++) begin
                bsum[i] <= '0;
                bcnt[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < BUCKETS; i++) begin
                if (do_slide && (PTR_W'(i) == oldest)) begin
                    bsum[i] <= '0;
                    bcnt[i] <= '0;
                end else if (do_event && (PTR_W'(i) == ptr)) begin
                    bsum[i] <= bsum[i] + in_data;
                    if (cnt_inc) begin
                        bcnt[i] <= bcnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Pointer, totals, fill level and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            fill      <= '0;
            tsum      <= '0;
            tcnt      <= '0;
            out_sum   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_full  <= 1'b0;
        end else begin
            // do_req already includes en, so a disabled cycle drops the pulse.
            out_valid <= do_req;
            if (en) begin
                tsum     <= tsum_next;
                tcnt     <= tcnt_next;
                fill     <= fill_next;
                out_full <= (fill_next == FILL_MAX);
                if (do_slide) begin
                    ptr <= oldest;
                end
            end
            if (do_req) begin
                out_sum <= tsum_next;
                out_cnt <= tcnt_next;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_agg.sv
// -----------------------------------------------------------------------------
// tb_sliding_window_agg
//
// Directed bench for sliding_window_agg with default parameters
// (DATA_W=64, BUCKETS=4, CNT_W=16). Inputs are driven 1 time unit after the
// rising edge and outputs are sampled at the same point, away from the edge.
// Expected responses are hand-computed constants; each request pushes its
// expected {sum, cnt} onto exp_q and the response check pops it.
// -----------------------------------------------------------------------------
module tb_sliding_window_agg;

    localparam int DATA_W  = 64;
    localparam int BUCKETS = 4;
    localparam int CNT_W   = 16;

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              slide;
    logic              req;
    logic [DATA_W-1:0] out_sum;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_valid;
    logic              out_full;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sliding_window_agg #(
        .DATA_W  (DATA_W),
        .BUCKETS (BUCKETS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .slide     (slide),
        .req       (req),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_full  (out_full)
    );

    // ---------------- scoreboard ----------------
    int n_checks;
    int n_errors;
    logic [DATA_W+CNT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pops the expected response and compares it with the DUT outputs.
    task automatic check_resp(input string tag);
        logic [DATA_W+CNT_W-1:0] e;
        e = exp_q.pop_front();
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".sum"}, out_sum, e[DATA_W+CNT_W-1:CNT_W]);
        check({tag, ".cnt"}, 64'(out_cnt), 64'(e[CNT_W-1:0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DATA_W-1:0] v, input logic ev, input logic sl, input logic rq);
        in_data  = v;
        in_valid = ev;
        slide    = sl;
        req      = rq;
        tick();
        in_data  = '0;
        in_valid = 1'b0;
        slide    = 1'b0;
        req      = 1'b0;
    endtask

    task automatic do_event(input logic [DATA_W-1:0] v);
        drive(v, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_slide();
        drive('0, 1'b0, 1'b1, 1'b0);
    endtask

    // Request with optional same-cycle event/slide; expected totals queued.
    task automatic do_req(input logic [DATA_W-1:0] v, input logic ev, input logic sl,
                          input logic [DATA_W-1:0] es, input logic [CNT_W-1:0] ec);
        exp_q.push_back({es, ec});
        drive(v, ev, sl, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        en       = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        slide    = 1'b0;
        req      = 1'b0;

        // 1. Reset held for two cycles, then one request on an empty window.
        tick();
        tick();
        check("rst.sum", out_sum, 64'd0);
        check("rst.cnt", 64'(out_cnt), 64'd0);
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.full", 64'(out_full), 64'd0);
        rst = 1'b0;
        do_req('0, 1'b0, 1'b0, 64'd0, 16'd0);
        check_resp("rst_req");
        tick();
        check("rst_req.pulse_end", 64'(out_valid), 64'd0);

        // 2. Single bucket: 1 + 2 + 3.
        do_reset();
        do_event(64'd1);
        do_event(64'd2);
        do_event(64'd3);
        do_req('0, 1'b0, 1'b0, 64'd6, 16'd3);
        check_resp("single");
        tick();
        check("single.hold_valid", 64'(out_valid), 64'd0);
        check("single.hold_sum", out_sum, 64'd6);

        // 3. Eviction: bucket holding 1 is evicted by the fourth slide.
        do_reset();
        do_event(64'd1);
        do_slide();
        do_event(64'd2);
        do_slide();
        check("evict.full_early", 64'(out_full), 64'd0);
        do_event(64'd3);
        do_slide();
        check("evict.full_at3", 64'(out_full), 64'd1);
        do_event(64'd4);
        do_slide();
        do_event(64'd5);
        do_req('0, 1'b0, 1'b0, 64'd14, 16'd4);
        check_resp("evict");
        check("evict.full", 64'(out_full), 64'd1);

        // 6. Asynchronous reset mid-cycle while out_valid is high.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.sum", out_sum, 64'd0);
        check("async_rst.cnt", 64'(out_cnt), 64'd0);
        check("async_rst.valid", 64'(out_valid), 64'd0);
        check("async_rst.full", 64'(out_full), 64'd0);
        tick();
        rst = 1'b0;
        // Disabled cycle: event 7 and req are ignored.
        en = 1'b0;
        drive(64'd7, 1'b1, 1'b0, 1'b1);
        check("en_low.valid", 64'(out_valid), 64'd0);
        check("en_low.sum", out_sum, 64'd0);
        en = 1'b1;
        do_req('0, 1'b0, 1'b0, 64'd0, 16'd0);
        check_resp("en_back");

        // 4. Simultaneous event/slide/req with window {1,2,3,4}, ptr on 4.
        do_reset();
        do_event(64'd1);
        do_slide();
        do_event(64'd2);
        do_slide();
        do_event(64'd3);
        do_slide();
        do_event(64'd4);
        do_req(64'd10, 1'b1, 1'b1, 64'd19, 16'd4);
        check_resp("simul");
        do_req('0, 1'b0, 1'b0, 64'd19, 16'd4);
        check_resp("simul.back2back");
        // Drain: buckets 2, 3 then the 4+10 bucket are evicted in turn.
        do_slide();
        do_req('0, 1'b0, 1'b1, 64'd14, 16'd2);
        check_resp("drain2");
        do_req('0, 1'b0, 1'b1, 64'd0, 16'd0);
        check_resp("drain3");
        do_req('0, 1'b0, 1'b1, 64'd0, 16'd0);
        check_resp("drain4");

        // 5. Two's complement wrap: (2^63-1) + 1 = -2^63.
        do_reset();
        do_event(64'h7FFF_FFFF_FFFF_FFFF);
        do_event(64'd1);
        do_req('0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 16'd2);
        check_resp("wrap");

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sliding_window_agg.md
# sliding_window_agg

- Parametrised sliding-window aggregator for the RTLola monitor datapath; sits between an input stream's event interface and the output-stream evaluation logic.
- Keeps a ring of `BUCKETS` time buckets. Each bucket holds a partial sum and an event count.
- On each evaluation request it returns the window sum and window count of all events in the retained buckets.
- Generalises the single fixed sliding window to configurable data width, bucket count and count width, with same-cycle event/slide/request resolution and a window-full indication.

## Interface
Parameters:
- `DATA_W`, 64, signed input data width; sum accumulators are also `DATA_W` wide.
- `BUCKETS`, 4, number of buckets in the window, ≥2, power of two.
- `CNT_W`, 16, width of the per-bucket and window event counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  clock enable; when low, all state holds and inputs are ignored.
- `in_data`  in  DATA_W  signed event value.
- `in_valid`  in  1  new event this cycle.
- `slide`  in  1  close the current bucket and start a new one.
- `req`  in  1  evaluation request.
- `out_sum`  out  DATA_W  signed window sum.
- `out_cnt`  out  CNT_W  window event count.
- `out_valid`  out  1  one-cycle pulse marking a response to `req`.
- `out_full`  out  1  at least `BUCKETS-1` slides have occurred since reset.

## Operation
**State**
- Bucket arrays `bsum[BUCKETS]` and `bcnt[BUCKETS]`.
- Write pointer `ptr`.
- Running totals `tsum` and `tcnt`.
- Fill counter `fill`, saturating at `BUCKETS-1`.

**Reset** clears all of the above and all outputs to 0.

**Event** (`en & in_valid`)
- `bsum[ptr] += in_data`, `bcnt[ptr] += 1`.
- `tsum += in_data`, `tcnt += 1`.

**Slide** (`en & slide`)
- Oldest bucket is `o = (ptr+1) mod BUCKETS`.
- `tsum -= bsum[o]`, `tcnt -= bcnt[o]`.
- `bsum[o]` and `bcnt[o]` cleared; `ptr <= o`; `fill` increments, saturating.

**Event and slide in the same cycle**
- The event belongs to the bucket being closed, `ptr`, so it stays in the window.
- Net update: `tsum <= tsum + in_data - bsum[o]`.
- `bsum[ptr]` must still receive the event even though `ptr` moves.

**Request** (`en & req`)
- `out_sum` and `out_cnt` are loaded with the post-update totals of that cycle, so same-cycle events and slides are included.
- `out_valid` is 1 for one cycle.
- `out_sum` and `out_cnt` hold their value until the next request.

**`out_full`** equals `fill == BUCKETS-1`. It is registered and updates together with `fill`.

**Arithmetic**
- Sums are two's complement and wrap modulo 2^DATA_W; there is no saturation.
- Per-bucket counters saturate at 2^CNT_W−1.
- `tcnt` is held as a true sum of the bucket counts. It is derived so that it never underflows on eviction.

**`en` low**
- No state change.
- `out_valid` is forced to 0 on the next edge.
- Outputs otherwise hold.

## Timing
- Latency from `req` to `out_valid` is exactly one cycle. Throughput is one request per cycle.
- A back-to-back `req` in every cycle gives `out_valid` high in every following cycle.
- Reset is asynchronous: every output goes to 0 immediately when `rst` rises, including mid-operation and while `out_valid` is high.
- The first edge after `rst` falls behaves like any normal cycle.
- A `slide` on every cycle is legal. After `BUCKETS` consecutive slides with no events, `tsum = 0`.
- The ring pointer wraps from `BUCKETS-1` to 0 with no bubble.

## Test plan
1. **Reset:** assert `rst` for 2 cycles → `out_sum=0`, `out_cnt=0`, `out_valid=0`, `out_full=0`; one `req` after release → `out_sum=0`, `out_cnt=0`, `out_valid=1` one cycle later.
2. **Single bucket:** events 1, 2, 3 on consecutive cycles, then `req` → next cycle `out_sum=6`, `out_cnt=3`.
3. **Eviction (`BUCKETS=4`):** events 1, 2, 3, 4, 5, each followed by a `slide` one cycle later; after the fifth event, `req` → `out_sum=14`, `out_cnt=4`, `out_full=1`.
4. **Simultaneous:** window holds buckets {1, 2, 3, 4} with `ptr` on the bucket holding 4; drive `in_valid` with 10, `slide` and `req` in one cycle → `out_sum=19`, `out_cnt=4`. A following `req` with no events → same values.
5. **Wrap:** event 2^63−1, then event 1, then `req` → `out_sum=-2^63`, `out_cnt=2`.
6. **Reset mid-operation and enable hold:**
   - After scenario 3, assert `rst` mid-cycle → outputs go to 0 before the next edge.
   - Then, with `en=0`, drive event 7 and `req` → no `out_valid` pulse.
   - Re-enable and `req` → `out_sum=0`.
